// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 core: LSU command encoding, trap cause
// codes and the LSU state type.
package jedro_1_defines;

    localparam int LSU_CTRL_BIT_STORE    = 4;
    localparam int LSU_CTRL_BIT_UNSIGNED = 3;

    localparam logic [3:0] CSR_MCAUSE_LOAD_ADDR_MISALIGNED  = 4'd4;
    localparam logic [3:0] CSR_MCAUSE_LOAD_ACCESS_FAULT     = 4'd5;
    localparam logic [3:0] CSR_MCAUSE_STORE_ADDR_MISALIGNED = 4'd6;
    localparam logic [3:0] CSR_MCAUSE_STORE_ACCESS_FAULT    = 4'd7;

    // Bit 4 = store, bit 3 = unsigned, bits [2:0] = byte-size mask.
    typedef enum logic [4:0] {
        LSU_NO_CMD             = 5'b00000,
        LSU_LOAD_BYTE          = 5'b00001,
        LSU_LOAD_HALF_WORD     = 5'b00011,
        LSU_LOAD_WORD          = 5'b00111,
        LSU_LOAD_BYTE_U        = 5'b01001,
        LSU_LOAD_HALF_WORD_U   = 5'b01011,
        LSU_STORE_BYTE         = 5'b10001,
        LSU_STORE_HALF_WORD    = 5'b10011,
        LSU_STORE_WORD         = 5'b10111
    } lsu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    function automatic logic lsu_cmd_legal(input logic [4:0] cmd);
        logic legal;
        legal = 1'b0;
        case (cmd)
            LSU_LOAD_BYTE, LSU_LOAD_HALF_WORD, LSU_LOAD_WORD,
            LSU_LOAD_BYTE_U, LSU_LOAD_HALF_WORD_U,
            LSU_STORE_BYTE, LSU_STORE_HALF_WORD, LSU_STORE_WORD: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/jedro_1_lsu_rdata_align.sv
// Load data alignment: shifts the addressed byte/half down to bit 0 and
// sign- or zero-extends it according to the command.
module jedro_1_lsu_rdata_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [4:0]  ctrl,
    output logic [31:0] data
);
    import jedro_1_defines::*;

    logic [31:0] shifted;
    logic        uns;
    logic        unused_store_bit;

    assign unused_store_bit = ctrl[LSU_CTRL_BIT_STORE];

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        uns     = ctrl[LSU_CTRL_BIT_UNSIGNED];
        data    = shifted;
        case (ctrl[2:0])
            3'b001:  data = {{24{shifted[7] & ~uns}}, shifted[7:0]};
            3'b011:  data = {{16{shifted[15] & ~uns}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/jedro_1_lsu.sv
// jedro_1 load-store unit: one outstanding req/gnt/rvalid access at a time,
// misalignment and bus-error trap reporting, aligned load write-back.
module jedro_1_lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  ctrl_valid_i,
    input  logic [4:0]            ctrl_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [4:0]            regdest_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [4:0]            regdest_o,
    output logic                  rf_wb_o,
    output logic                  done_o,
    output logic                  exc_o,
    output logic [3:0]            exc_cause_o,
    output logic [DATA_WIDTH-1:0] exc_addr_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_addr_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
    input  logic                  data_err_i
);
    import jedro_1_defines::*;

    lsu_state_e            state_q, state_d;
    logic [4:0]            ctrl_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [4:0]            regdest_q;

    logic                  accept;
    logic                  misaligned;
    logic                  in_req;
    logic                  resp_done;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] load_data;

    logic                  rf_wb_q, done_q, exc_q;
    logic [3:0]            exc_cause_q;
    logic [DATA_WIDTH-1:0] exc_addr_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign accept    = (state_q == IDLE) && ctrl_valid_i && lsu_cmd_legal(ctrl_i);
    assign in_req    = (state_q == REQ);
    assign resp_done = (state_q == RESP) && data_rvalid_i;

    always_comb begin
        misaligned = 1'b0;
        case (ctrl_i[2:0])
            3'b011:  misaligned = addr_i[0];
            3'b111:  misaligned = |addr_i[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !misaligned) state_d = REQ;
            REQ:     if (data_gnt_i) state_d = RESP;
            RESP:    if (data_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ctrl_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            regdest_q <= '0;
        end else if (accept) begin
            ctrl_q    <= ctrl_i;
            addr_q    <= addr_i;
            wdata_q   <= wdata_i;
            regdest_q <= regdest_i;
        end
    end

    // Completion strobes are single-cycle; cause, fault address and load
    // data keep their last value until the next event that updates them.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rf_wb_q     <= 1'b0;
            done_q      <= 1'b0;
            exc_q       <= 1'b0;
            exc_cause_q <= '0;
            exc_addr_q  <= '0;
            rdata_q     <= '0;
        end else begin
            rf_wb_q <= 1'b0;
            done_q  <= 1'b0;
            exc_q   <= 1'b0;
            if (accept && misaligned) begin
                done_q      <= 1'b1;
                exc_q       <= 1'b1;
                exc_cause_q <= ctrl_i[LSU_CTRL_BIT_STORE] ? CSR_MCAUSE_STORE_ADDR_MISALIGNED
                                                          : CSR_MCAUSE_LOAD_ADDR_MISALIGNED;
                exc_addr_q  <= addr_i;
            end
            if (resp_done) begin
                done_q <= 1'b1;
                if (data_err_i) begin
                    exc_q       <= 1'b1;
                    exc_cause_q <= ctrl_q[LSU_CTRL_BIT_STORE] ? CSR_MCAUSE_STORE_ACCESS_FAULT
                                                              : CSR_MCAUSE_LOAD_ACCESS_FAULT;
                    exc_addr_q  <= addr_q;
                end else if (!ctrl_q[LSU_CTRL_BIT_STORE]) begin
                    rf_wb_q <= 1'b1;
                    rdata_q <= load_data;
                end
            end
        end
    end

    always_comb begin
        be        = 4'b1111;
        bus_wdata = wdata_q;
        case (ctrl_q[2:0])
            3'b001: begin
                be        = 4'b0001 << addr_q[1:0];
                bus_wdata = {4{wdata_q[7:0]}};
            end
            3'b011: begin
                be        = 4'b0011 << {addr_q[1], 1'b0};
                bus_wdata = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    jedro_1_lsu_rdata_align u_rdata_align (
        .rdata (data_rdata_i),
        .addr  (addr_q[1:0]),
        .ctrl  (ctrl_q),
        .data  (load_data)
    );

    // Bus outputs are only driven while requesting so the port idles at zero.
    assign data_req_o   = in_req;
    assign data_we_o    = in_req & ctrl_q[LSU_CTRL_BIT_STORE];
    assign data_be_o    = in_req ? be : 4'b0000;
    assign data_addr_o  = in_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    assign data_wdata_o = in_req ? bus_wdata : '0;

    assign ready_o     = (state_q == IDLE);
    assign rdata_o     = rdata_q;
    assign regdest_o   = regdest_q;
    assign rf_wb_o     = rf_wb_q;
    assign done_o      = done_q;
    assign exc_o       = exc_q;
    assign exc_cause_o = exc_cause_q;
    assign exc_addr_o  = exc_addr_q;

endmodule

// File: doc/jedro_1_lsu.md
Name: jedro_1_lsu

Overview:
- Load-store unit of the jedro_1 core. It consumes the decoded `lsu_ctrl_e` command, the effective address and the store data from the decode/execute stage.
- It drives a single-outstanding req/gnt/rvalid data-memory port and returns aligned, sign- or zero-extended load data to the register-file write-back.
- It detects misaligned accesses and bus errors and reports them to the CSR/trap logic using the `CSR_MCAUSE_*` codes.

Parameters:
- `DATA_WIDTH`, 32: data and address width. Only 32 is supported.

Ports:
- `clk_i`  in  1  core clock
- `rstn_i`  in  1  asynchronous active-low reset
- `ctrl_valid_i`  in  1  command valid from execute
- `ctrl_i`  in  5  `lsu_ctrl_e` command
- `addr_i`  in  32  effective address
- `wdata_i`  in  32  store data (rs2)
- `regdest_i`  in  5  load destination register
- `ready_o`  out  1  LSU idle; a command may be accepted
- `rdata_o`  out  32  extended load data
- `regdest_o`  out  5  destination register for write-back
- `rf_wb_o`  out  1  one-cycle load write-back strobe
- `done_o`  out  1  one-cycle completion strobe (load or store, including faults)
- `exc_o`  out  1  one-cycle exception strobe
- `exc_cause_o`  out  4  `CSR_MCAUSE_*` value
- `exc_addr_o`  out  32  faulting address (for `mtval`)
- `data_req_o`  out  1  bus request
- `data_gnt_i`  in  1  bus grant
- `data_we_o`  out  1  1 = write
- `data_be_o`  out  4  byte enables
- `data_addr_o`  out  32  word-aligned address, i.e. `{addr[31:2],2'b00}`
- `data_wdata_o`  out  32  replicated store data
- `data_rvalid_i`  in  1  response valid
- `data_rdata_i`  in  32  read data
- `data_err_i`  in  1  bus error, qualified by `data_rvalid_i`

Behaviour:
- Reset: every output is 0 except `ready_o`, which is 1. State is IDLE.
- Reset mid-transaction abandons the transaction and returns to IDLE. The memory side is reset by the same `rstn_i`.
- FSM states: IDLE, REQ, RESP.
- Accept: in IDLE, `ctrl_valid_i=1` and `ctrl_i != LSU_NO_CMD`. On accept, register `ctrl`, `addr`, `wdata` and `regdest`; `ready_o` drops the next cycle.
  - `LSU_NO_CMD` or any undefined encoding with valid is ignored and the LSU stays in IDLE.
  - `ctrl_valid_i` while not ready is ignored.
- Misaligned check at accept:
  - Half-word with `addr[0]=1` is misaligned.
  - Word with `addr[1:0]!=0` is misaligned.
  - Misaligned accesses issue no bus request. The next cycle the LSU stays in IDLE and pulses `exc_o` and `done_o`, with cause 4 (load) or 6 (store) and `exc_addr_o = addr`.
- Aligned access: IDLE→REQ.
  - In REQ, `data_req_o=1` with address, `we`, `be` and `wdata` held stable until `data_gnt_i`.
  - Grant moves REQ→RESP and drops `req` the following cycle.
- Bus protocol guarantee: the memory asserts `rvalid` no earlier than the cycle after `gnt`. An `rvalid` seen outside RESP is ignored.
- RESP→IDLE on `data_rvalid_i`. In the following cycle:
  - Load with `err=0`: `rf_wb_o=1`, `rdata_o` and `regdest_o` valid.
  - Store: `done_o` only.
  - `err=1`: `exc_o=1` with cause 5 (load) or `CSR_MCAUSE_STORE_ADDR_MISALIGNED+1=7` (store access fault), `exc_addr_o = addr`, and no `rf_wb_o`.
- `done_o` accompanies every completion.
- Latency: with zero-wait gnt and rvalid, a command accepted in cycle N gives `req` in N+1, `rvalid` in N+2, and `rf_wb_o`/`done_o` in N+3. `ready_o` is 1 in N+3, so the next accept is possible in N+3.
- Byte enables:
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << {addr[1],1'b0}`.
  - Word: `4'b1111`.
- Store data:
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: pass-through.
- Load extract: `data_rdata_i >> (8*addr[1:0])`, then sign- or zero-extend from bit 7 (byte) or bit 15 (half) according to `ctrl[3]` (unsigned). Word loads are not extended.
- `rdata_o` holds its value until the next write-back.
- `lsu_ctrl_e` field use:
  - Bit 4 = store.
  - Bit 3 = unsigned.
  - Bits [2:0] = size mask (001 byte, 011 half, 111 word).

Decomposition:
- Add to `jedro_1_defines`:
  - `LSU_CTRL_BIT_STORE=4`, `LSU_CTRL_BIT_UNSIGNED=3`.
  - `CSR_MCAUSE_STORE_ACCESS_FAULT=7`.
  - `lsu_state_e` {IDLE, REQ, RESP}.
- One combinational sub-module, `jedro_1_lsu_rdata_align`: shift plus sign/zero extension, with inputs `rdata`, `addr[1:0]`, `ctrl` and output of 32 bits. The FSM stays in the top module.

Test Plan:
- LB at `0x8000_0003`, memory word `0x80FF_1234`, zero-wait → `data_addr_o=0x8000_0000`, `be=1000`; at N+3 `rf_wb_o=1`, `rdata_o=0xFFFF_FF80`. Same access with LBU → `0x0000_0080`.
- SH at `0x8000_0102`, `wdata=0xDEAD_BEEF` → `be=1100`, `data_wdata_o=0xBEEF_BEEF`, `we=1`; `done_o` pulses and `rf_wb_o` stays 0.
- LW at `0x8000_0002` → no `data_req_o`; next cycle `exc_o=1`, `cause=4`, `exc_addr_o=0x8000_0002`, `ready_o=1`. SW at `0x8000_0001` → `cause=6`.
- LH at `0x8000_0000` with `gnt` withheld 3 cycles → `req`, `addr` and `be` stable all 4 cycles; `ctrl_valid_i` pulsed during the wait is ignored, and exactly one write-back follows.
- LW with `rvalid` and `err=1` → `exc_o=1`, `cause=5`, no `rf_wb_o`. SW with `err=1` → `cause=7`.
- `rstn_i` asserted while in RESP → all outputs 0 and `ready_o=1` immediately; a stale `rvalid` after release causes no `rf_wb_o`.
